// File: rtl/pkt_a_pkg.sv
// rtl/pkt_a_pkg.sv - shared types and constants for the channel A packet filter
package pkt_a_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  localparam int SOP_BIT  = 9;
  localparam int EOP_BIT  = 8;
  localparam int DATA_MSB = 7;
  localparam int ENTRY_W  = 10;

  localparam logic [15:0] COUNTER_MAX = 16'hFFFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == COUNTER_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pkt_a_buf_ram.sv
// rtl/pkt_a_buf_ram.sv - simple dual-port packet buffer with registered read
module pkt_a_buf_ram
  import pkt_a_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic               clk_a,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [ADDR_W-1:0]  raddr_i,
  output logic [ENTRY_W-1:0] rdata_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_a) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/pkt_a_filter.sv
// rtl/pkt_a_filter.sv - store-and-forward packet filter feeding merge channel A
module pkt_a_filter
  import pkt_a_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int MIN_LEN = 2
) (
  input  logic        clk_a,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_sop,
  input  logic        din_eop,
  input  logic        din_vld,
  input  logic        din_err,
  output logic [7:0]  data_a,
  output logic        data_a_sop,
  output logic        data_a_eop,
  output logic        data_a_vld,
  output logic [15:0] pkt_good_cnt,
  output logic [15:0] pkt_drop_cnt,
  output logic        ovf
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  wr_state_e          state_q, state_d;
  logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [15:0]        good_cnt_q, drop_cnt_q;
  logic               good_inc, drop_inc, ovf_d, ovf_q;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic               full, full_base, readable, rd_vld_q;
  logic [ENTRY_W-1:0] rdata;
  logic [7:0]         data_q;
  logic               sop_q, eop_q, vld_q;

  assign full      = (wr_ptr_q - rd_ptr_q) == FULL_LVL;
  // space check for a packet restarting at commit_ptr (uncommitted bytes are discarded)
  assign full_base = (commit_ptr_q - rd_ptr_q) == FULL_LVL;
  assign readable  = rd_ptr_q != commit_ptr_q;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    we           = 1'b0;
    waddr        = wr_ptr_q[ADDR_W-1:0];
    good_inc     = 1'b0;
    drop_inc     = 1'b0;
    ovf_d        = 1'b0;
    if (din_vld) begin
      if (din_sop) begin
        if (state_q == ST_RECV) drop_inc = 1'b1;
        wr_ptr_d = commit_ptr_q;
        if (full_base) begin
          drop_inc = 1'b1;
          ovf_d    = 1'b1;
          state_d  = din_eop ? ST_IDLE : ST_DROP;
        end else begin
          we    = 1'b1;
          waddr = commit_ptr_q[ADDR_W-1:0];
          len_d = LEN_W'(1);
          if (!din_eop) begin
            wr_ptr_d = commit_ptr_q + 1'b1;
            state_d  = ST_RECV;
          end else begin
            state_d = ST_IDLE;
            if (MIN_LEN <= 1) begin
              wr_ptr_d     = commit_ptr_q + 1'b1;
              commit_ptr_d = commit_ptr_q + 1'b1;
              good_inc     = 1'b1;
            end else begin
              drop_inc = 1'b1;
            end
          end
        end
      end else if (state_q == ST_RECV) begin
        if (din_err || full || (len_q == LEN_W'(MAX_LEN))) begin
          wr_ptr_d = commit_ptr_q;
          drop_inc = 1'b1;
          ovf_d    = full;
          state_d  = din_eop ? ST_IDLE : ST_DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          len_d    = len_q + 1'b1;
          if (din_eop) begin
            state_d = ST_IDLE;
            if (int'(len_q) + 1 >= MIN_LEN) begin
              commit_ptr_d = wr_ptr_q + 1'b1;
              good_inc     = 1'b1;
            end else begin
              wr_ptr_d = commit_ptr_q;
              drop_inc = 1'b1;
            end
          end
        end
      end else if (state_q == ST_DROP && din_eop) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      good_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      ovf_q        <= 1'b0;
      rd_vld_q     <= 1'b0;
      data_q       <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      vld_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      len_q        <= len_d;
      ovf_q        <= ovf_d;
      if (good_inc) good_cnt_q <= sat_inc(good_cnt_q);
      if (drop_inc) drop_cnt_q <= sat_inc(drop_cnt_q);
      if (readable) rd_ptr_q <= rd_ptr_q + 1'b1;
      rd_vld_q <= readable;
      vld_q    <= rd_vld_q;
      sop_q    <= rd_vld_q & rdata[SOP_BIT];
      eop_q    <= rd_vld_q & rdata[EOP_BIT];
      data_q   <= rdata[DATA_MSB:0];
    end
  end

  pkt_a_buf_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_a   (clk_a),
    .we_i    (we),
    .waddr_i (waddr),
    .wdata_i ({din_sop, din_eop, din}),
    .re_i    (readable),
    .raddr_i (rd_ptr_q[ADDR_W-1:0]),
    .rdata_o (rdata)
  );

  assign data_a       = data_q;
  assign data_a_sop   = sop_q;
  assign data_a_eop   = eop_q;
  assign data_a_vld   = vld_q;
  assign pkt_good_cnt = good_cnt_q;
  assign pkt_drop_cnt = drop_cnt_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_pkt_a_filter.sv
// tb/tb_pkt_a_filter.sv - scoreboard bench for pkt_a_filter (MIN_LEN 2 and MIN_LEN 1 instances)
module tb_pkt_a_filter;

  logic        clk_a = 1'b0;
  logic        rst_n;
  logic [7:0]  din;
  logic        din_sop, din_eop, din_err, din_vld0, din_vld1;
  logic [7:0]  data0, data1;
  logic        sop0, eop0, vld0, sop1, eop1, vld1, ovf0, ovf1;
  logic [15:0] good0, drop0, good1, drop1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf0_n = 0;
  int ovf1_n = 0;
  logic [9:0] exp0[$];
  logic [9:0] exp1[$];

  always #5 clk_a = ~clk_a;
  always @(posedge clk_a) cyc <= cyc + 1;

  pkt_a_filter #(.DEPTH(256), .ADDR_W(8), .MAX_LEN(64), .MIN_LEN(2)) dut0 (
    .clk_a(clk_a), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
    .din_vld(din_vld0), .din_err(din_err), .data_a(data0), .data_a_sop(sop0),
    .data_a_eop(eop0), .data_a_vld(vld0), .pkt_good_cnt(good0), .pkt_drop_cnt(drop0),
    .ovf(ovf0)
  );

  pkt_a_filter #(.DEPTH(64), .ADDR_W(6), .MAX_LEN(64), .MIN_LEN(1)) dut1 (
    .clk_a(clk_a), .rst_n(rst_n), .din(din), .din_sop(din_sop), .din_eop(din_eop),
    .din_vld(din_vld1), .din_err(din_err), .data_a(data1), .data_a_sop(sop1),
    .data_a_eop(eop1), .data_a_vld(vld1), .pkt_good_cnt(good1), .pkt_drop_cnt(drop1),
    .ovf(ovf1)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: every output byte must match the head of the scoreboard queue
  always @(negedge clk_a) begin
    if (rst_n) begin
      if (ovf0) ovf0_n++;
      if (ovf1) ovf1_n++;
      if (vld0) begin
        if (exp0.size() == 0) check("dut0_unexpected_byte", {sop0, eop0, data0}, -1);
        else check("dut0_byte", {sop0, eop0, data0}, exp0.pop_front());
      end
      if (vld1) begin
        if (exp1.size() == 0) check("dut1_unexpected_byte", {sop1, eop1, data1}, -1);
        else check("dut1_byte", {sop1, eop1, data1}, exp1.pop_front());
      end
    end
  end

  task automatic send(input int sel, input logic [7:0] d, input logic s, input logic e,
                      input logic er);
    @(posedge clk_a);
    #1;
    din = d; din_sop = s; din_eop = e; din_err = er;
    din_vld0 = (sel == 0);
    din_vld1 = (sel == 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_a);
      #1;
      din_vld0 = 1'b0; din_vld1 = 1'b0;
      din_sop = 1'b0; din_eop = 1'b0; din_err = 1'b0;
    end
  endtask

  task automatic send_pkt(input int sel, input int len, input int first, input int step,
                          input int err_idx, input bit term, input bit keep);
    for (int i = 0; i < len; i++) begin
      logic [7:0] d;
      logic s, e;
      d = 8'(first + i * step);
      s = (i == 0);
      e = term && (i == len - 1);
      send(sel, d, s, e, (i == err_idx));
      if (keep) begin
        if (sel == 0) exp0.push_back({s, e, d});
        else exp1.push_back({s, e, d});
      end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    idle(1);
    while ((exp0.size() != 0 || exp1.size() != 0) && t < 3000) begin
      @(negedge clk_a);
      t++;
    end
    idle(4);
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    din = '0; din_sop = 1'b0; din_eop = 1'b0; din_err = 1'b0;
    din_vld0 = 1'b0; din_vld1 = 1'b0;
    repeat (3) @(posedge clk_a);
    #1 rst_n = 1'b1;
    @(negedge clk_a);
    check("reset_vld0", vld0, 0);
    check("reset_good0", good0, 0);
    check("reset_drop0", drop0, 0);
    check("reset_ovf0", ovf0, 0);
    check("reset_vld1", vld1, 0);

    // 5-byte packet 11..55 with latency check on the first output byte
    send_pkt(0, 5, 8'h11, 8'h11, -1, 1, 1);
    k = cyc;
    idle(1);
    @(negedge clk_a);
    @(negedge clk_a);
    check("latency_t2_idle", vld0, 0);
    @(negedge clk_a);
    check("latency_t3_valid", vld0, 1);
    drain();
    check("t1_cycle_ref", (cyc > k) ? 1 : 0, 1);
    check("t1_good", good0, 1);
    check("t1_drop", drop0, 0);

    // poisoned 4-byte packet, then good 3-byte packet
    send_pkt(0, 4, 8'h40, 1, 1, 1, 0);
    send_pkt(0, 3, 8'h50, 1, -1, 1, 1);
    drain();
    check("t2_good", good0, 2);
    check("t2_drop", drop0, 1);

    // oversize 70-byte packet, then 2-byte packet
    send_pkt(0, 70, 8'h00, 1, -1, 1, 0);
    send_pkt(0, 2, 8'hA0, 1, -1, 1, 1);
    drain();
    check("t3_good", good0, 3);
    check("t3_drop", drop0, 2);

    // sop arrives as byte 3 of an unfinished packet
    send_pkt(0, 2, 8'hC0, 1, -1, 0, 0);
    send_pkt(0, 4, 8'hD0, 1, -1, 1, 1);
    drain();
    check("t4_good", good0, 4);
    check("t4_drop", drop0, 3);

    // 1-byte packet: dropped with MIN_LEN=2, emitted with MIN_LEN=1
    send_pkt(0, 1, 8'hE5, 0, -1, 1, 0);
    send_pkt(1, 1, 8'hE6, 0, -1, 1, 1);
    drain();
    check("t5_good0", good0, 4);
    check("t5_drop0", drop0, 4);
    check("t5_good1", good1, 1);

    // five back-to-back 64-byte packets; the running output keeps occupancy far below 256
    for (int p = 0; p < 5; p++) send_pkt(0, 64, p * 16, 1, -1, 1, 1);
    drain();
    check("t6_good", good0, 9);
    check("t6_drop", drop0, 4);
    check("t6_sum_delta", (good0 - 4) + (drop0 - 4), 5);
    check("t6_ovf0_pulses", ovf0_n, 0);

    // DEPTH=64: a second packet right behind a full committed one overflows
    send_pkt(1, 64, 8'h00, 1, -1, 1, 1);
    send_pkt(1, 64, 8'h80, 1, -1, 1, 0);
    drain();
    check("t7_ovf1_pulses", ovf1_n, 1);
    check("t7_good1", good1, 2);
    check("t7_drop1", drop1, 1);
    send_pkt(1, 1, 8'h3C, 0, -1, 1, 1);
    drain();
    check("t7_good1_after", good1, 3);

    check("exp0_empty", exp0.size(), 0);
    check("exp1_empty", exp1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
